// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- IF stage of the RV32I pipeline.
//
// Owns the fetch PC and issues in-order word fetches to instruction memory.
// Returned words go into a small instruction buffer. The head of that buffer
// feeds the IF/ID register (instr_decode / pc_decode) for decode and control.
// A redirect (flush_if, with the target picked by pc_sel) retargets the PC and
// clears the buffer. Responses to requests already in flight are counted and
// discarded as they come back.
//
// Ports
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   pc_sel                next-PC source: FOUR / BRANCH / JAL / JALR
//   br_target             branch target from decode
//   jal_target            JAL target from decode
//   jalr_target           JALR target from decode (low two bits are cleared here)
//   stall_if              hold the IF/ID register and the buffer head
//   flush_if              redirect to the target selected by pc_sel
//   imem_req_valid/ready  fetch request handshake
//   imem_req_addr         word-aligned fetch address
//   imem_rsp_valid/data   in-order response word
//   instr_decode          IF/ID instruction (NOP_INSTR when no instruction)
//   pc_decode             PC of instr_decode
//   instr_valid_decode    instr_decode is a real fetched word
// -----------------------------------------------------------------------------
`ifndef PC_SEL_WIDTH
`define PC_SEL_WIDTH 2
`endif
`ifndef PC_SEL_FOUR
`define PC_SEL_FOUR 2'd0
`endif
`ifndef PC_SEL_BRANCH
`define PC_SEL_BRANCH 2'd1
`endif
`ifndef PC_SEL_JAL
`define PC_SEL_JAL 2'd2
`endif
`ifndef PC_SEL_JALR
`define PC_SEL_JALR 2'd3
`endif

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [`PC_SEL_WIDTH-1:0] pc_sel,
    input  logic [31:0]              br_target,
    input  logic [31:0]              jal_target,
    input  logic [31:0]              jalr_target,
    input  logic                     stall_if,
    input  logic                     flush_if,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [31:0]              imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    output logic [31:0]              instr_decode,
    output logic [31:0]              pc_decode,
    output logic                     instr_valid_decode
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W  = (CW+1)'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(BUF_DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Control state
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_count;
    logic [PW-1:0] buf_wr;
    logic [PW-1:0] buf_rd;
    logic [PW-1:0] pcq_wr;
    logic [PW-1:0] pcq_rd;

    // Storage: PCs of live (non-dropped) requests, and the instruction buffer
    logic [31:0] pcq_mem   [BUF_DEPTH];
    logic [31:0] buf_instr [BUF_DEPTH];
    logic [31:0] buf_pc    [BUF_DEPTH];

    logic          take_redirect;
    logic [31:0]   target_raw;
    logic [31:0]   redirect_target;
    logic          buf_pop;
    logic          buf_push;
    logic          req_fire;
    logic          rsp_drop;
    logic [CW:0]   inflight;
    logic [CW-1:0] outstanding_next;

    // Stall wins over flush: the branch resolves again once the stall lifts.
    // pc_sel=FOUR together with flush_if is not a legal redirect and is ignored.
    assign take_redirect = flush_if && !stall_if && (pc_sel != `PC_SEL_FOUR);

    always_comb begin
        target_raw = jal_target;
        case (pc_sel)
            `PC_SEL_BRANCH: target_raw = br_target;
            `PC_SEL_JAL:    target_raw = jal_target;
            `PC_SEL_JALR:   target_raw = jalr_target;
            default:        target_raw = jal_target;
        endcase
    end

    assign redirect_target = target_raw & ~32'h3;

    assign buf_pop  = !stall_if && !take_redirect && (buf_count != '0);
    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign buf_push = imem_rsp_valid && (drop_cnt == '0) && !take_redirect;

    // Occupancy counts the entry leaving the buffer this cycle. A new request's
    // word can come back no earlier than next cycle, so that slot is free by
    // then. This keeps one instruction per cycle with a 1-cycle memory.
    assign inflight = {1'b0, buf_count} - (CW+1)'(buf_pop) + {1'b0, outstanding};

    assign imem_req_valid = !rst && !take_redirect && (inflight < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    // Control and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc           <= RESET_PC;
            outstanding        <= '0;
            drop_cnt           <= '0;
            buf_count          <= '0;
            buf_wr             <= '0;
            buf_rd             <= '0;
            pcq_wr             <= '0;
            pcq_rd             <= '0;
            instr_decode       <= NOP_INSTR;
            pc_decode          <= RESET_PC;
            instr_valid_decode <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if (take_redirect) begin
                // Every request still in flight is discarded as it returns.
                // This includes a response that arrives in this same cycle.
                fetch_pc           <= redirect_target;
                drop_cnt           <= outstanding - CW'(imem_rsp_valid);
                buf_count          <= '0;
                buf_wr             <= '0;
                buf_rd             <= '0;
                pcq_wr             <= '0;
                pcq_rd             <= '0;
                instr_decode       <= NOP_INSTR;
                instr_valid_decode <= 1'b0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    pcq_wr   <= ptr_inc(pcq_wr);
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (buf_push) begin
                    pcq_rd <= ptr_inc(pcq_rd);
                    buf_wr <= ptr_inc(buf_wr);
                end
                if (buf_pop) begin
                    buf_rd <= ptr_inc(buf_rd);
                end
                buf_count <= buf_count + CW'(buf_push) - CW'(buf_pop);
                if (!stall_if) begin
                    if (buf_count != '0) begin
                        instr_decode       <= buf_instr[buf_rd];
                        pc_decode          <= buf_pc[buf_rd];
                        instr_valid_decode <= 1'b1;
                    end else begin
                        instr_decode       <= NOP_INSTR;
                        instr_valid_decode <= 1'b0;
                    end
                end
            end
        end
    end

    // Data storage (unreset; guarded by the control pointers above)
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr] <= fetch_pc;
        end
        if (buf_push) begin
            buf_instr[buf_wr] <= imem_rsp_data;
            buf_pc[buf_wr]    <= pcq_mem[pcq_rd];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- directed bench for fetch_unit with an in-order instruction
// memory model. The model has configurable latency and random ready.
// Each stored word is {pc[15:0], ~pc[15:0]}, so every instruction identifies
// the PC it came from.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [1:0]  SEL_FOUR = 2'd0;
    localparam logic [1:0]  SEL_BR   = 2'd1;
    localparam logic [1:0]  SEL_JAL  = 2'd2;
    localparam logic [1:0]  SEL_JALR = 2'd3;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_sel;
    logic [31:0] br_target;
    logic [31:0] jal_target;
    logic [31:0] jalr_target;
    logic        stall_if;
    logic        flush_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr_decode;
    logic [31:0] pc_decode;
    logic        instr_valid_decode;

    fetch_unit dut (
        .clk                (clk),
        .rst                (rst),
        .pc_sel             (pc_sel),
        .br_target          (br_target),
        .jal_target         (jal_target),
        .jalr_target        (jalr_target),
        .stall_if           (stall_if),
        .flush_if           (flush_if),
        .imem_req_valid     (imem_req_valid),
        .imem_req_ready     (imem_req_ready),
        .imem_req_addr      (imem_req_addr),
        .imem_rsp_valid     (imem_rsp_valid),
        .imem_rsp_data      (imem_rsp_data),
        .instr_decode       (instr_decode),
        .pc_decode          (pc_decode),
        .instr_valid_decode (instr_valid_decode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] acc_log[$];
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;
    bit          rand_ready;
    logic [31:0] exp_pc;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // One clock cycle: drive memory inputs, capture the handshake, advance.
    task automatic tick();
        logic        acc;
        logic        fire;
        logic [31:0] acc_addr;
        int          d;
        imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        fire     = imem_rsp_valid;
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            last_due = cyc;
        end else begin
            if (fire) void'(mq.pop_front());
            if (acc) begin
                d = cyc + $urandom_range(lat_min, lat_max) - 1;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq.push_back('{acc_addr, d});
                acc_log.push_back(acc_addr);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (instr_valid_decode !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid_decode);
        end
        n_checks++;
        if (instr_decode !== NOP) begin
            n_fail++; $display("FAIL reset_instr: got %h expected %h", instr_decode, NOP);
        end
        n_checks++;
        if (pc_decode !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h expected 00000000", pc_decode);
        end
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        rst = 1'b0;
        acc_log.delete();
        exp_pc = 32'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (instr_valid_decode !== 1'b0) begin
                n_fail++; $display("FAIL stream_early_valid[%0d]: got %b expected 0", i, instr_valid_decode);
            end
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if (instr_valid_decode !== 1'b1 || pc_decode !== exp_pc || instr_decode !== mem_word(exp_pc)) begin
                n_fail++;
                $display("FAIL stream_out[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, instr_valid_decode, pc_decode, instr_decode, exp_pc, mem_word(exp_pc));
            end
            exp_pc += 32'd4;
        end
        for (int i = 0; i < 4; i++) begin
            want = 32'(i * 4);
            n_checks++;
            if (acc_log.size() <= i || acc_log[i] !== want) begin
                n_fail++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i,
                                   (acc_log.size() > i) ? acc_log[i] : 32'hxxxxxxxx, want);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] h_instr;
        logic [31:0] h_pc;
        logic        h_valid;
        int          nvalid;
        h_instr = instr_decode;
        h_pc    = pc_decode;
        h_valid = instr_valid_decode;
        stall_if = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (instr_decode !== h_instr || pc_decode !== h_pc || instr_valid_decode !== h_valid) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got pc=%h instr=%h v=%b expected pc=%h instr=%h v=%b",
                         i, pc_decode, instr_decode, instr_valid_decode, h_pc, h_instr, h_valid);
            end
        end
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_req_stop: got %b expected 0", imem_req_valid);
        end
        stall_if = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (instr_valid_decode) begin
                n_checks++;
                if (pc_decode !== exp_pc || instr_decode !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL stall_resume[%0d]: got pc=%h instr=%h expected pc=%h",
                                       i, pc_decode, instr_decode, exp_pc);
                end
                exp_pc += 32'd4;
                nvalid++;
            end
        end
        n_checks++;
        if (nvalid != 8) begin
            n_fail++; $display("FAIL stall_resume_rate: got %0d expected 8", nvalid);
        end
    endtask

    task automatic test_flush();
        int guard;
        lat_min = 3;
        lat_max = 3;
        guard = 0;
        while (mq.size() < 2 && guard < 12) begin
            tick();
            if (instr_valid_decode) begin
                n_checks++;
                if (pc_decode !== exp_pc) begin
                    n_fail++; $display("FAIL flush_pre_pc: got %h expected %h", pc_decode, exp_pc);
                end
                exp_pc += 32'd4;
            end
            guard++;
        end
        n_checks++;
        if (mq.size() != 2) begin
            n_fail++; $display("FAIL flush_outstanding: got %0d expected 2", mq.size());
        end
        flush_if   = 1'b1;
        pc_sel     = SEL_JAL;
        jal_target = 32'h0000_0100;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_req_valid: got %b expected 0", imem_req_valid);
        end
        tick();
        flush_if = 1'b0;
        pc_sel   = SEL_FOUR;
        n_checks++;
        if (instr_valid_decode !== 1'b0 || instr_decode !== NOP) begin
            n_fail++; $display("FAIL flush_bubble: got v=%b instr=%h expected v=0 instr=%h",
                               instr_valid_decode, instr_decode, NOP);
        end
        acc_log.delete();
        guard = 0;
        while (!instr_valid_decode && guard < 15) begin
            tick();
            if (!instr_valid_decode) begin
                n_checks++;
                if (instr_decode !== NOP) begin
                    n_fail++; $display("FAIL flush_gap_nop: got %h expected %h", instr_decode, NOP);
                end
            end
            guard++;
        end
        n_checks++;
        if (instr_valid_decode !== 1'b1 || pc_decode !== 32'h100 || instr_decode !== mem_word(32'h100)) begin
            n_fail++; $display("FAIL flush_target: got v=%b pc=%h instr=%h expected v=1 pc=00000100 instr=%h",
                               instr_valid_decode, pc_decode, instr_decode, mem_word(32'h100));
        end
        n_checks++;
        if (acc_log.size() == 0 || acc_log[0] !== 32'h100) begin
            n_fail++; $display("FAIL flush_req_addr: got %h expected 00000100",
                               (acc_log.size() > 0) ? acc_log[0] : 32'hxxxxxxxx);
        end
        exp_pc  = 32'h104;
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (instr_valid_decode) begin
                n_checks++;
                if (pc_decode !== exp_pc) begin
                    n_fail++; $display("FAIL flush_post_pc: got %h expected %h", pc_decode, exp_pc);
                end
                exp_pc += 32'd4;
            end
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] h_instr;
        logic [31:0] h_pc;
        logic        h_valid;
        int          guard;
        h_instr   = instr_decode;
        h_pc      = pc_decode;
        h_valid   = instr_valid_decode;
        flush_if  = 1'b1;
        stall_if  = 1'b1;
        pc_sel    = SEL_BR;
        br_target = 32'h0000_0300;
        tick();
        n_checks++;
        if (instr_decode !== h_instr || pc_decode !== h_pc || instr_valid_decode !== h_valid) begin
            n_fail++; $display("FAIL stallflush_hold: got pc=%h v=%b expected pc=%h v=%b",
                               pc_decode, instr_valid_decode, h_pc, h_valid);
        end
        stall_if = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL stallflush_req_valid: got %b expected 0", imem_req_valid);
        end
        tick();
        flush_if = 1'b0;
        pc_sel   = SEL_FOUR;
        n_checks++;
        if (instr_valid_decode !== 1'b0 || instr_decode !== NOP) begin
            n_fail++; $display("FAIL stallflush_bubble: got v=%b instr=%h expected v=0 instr=%h",
                               instr_valid_decode, instr_decode, NOP);
        end
        acc_log.delete();
        guard = 0;
        while (!instr_valid_decode && guard < 10) begin
            tick();
            guard++;
        end
        n_checks++;
        if (instr_valid_decode !== 1'b1 || pc_decode !== 32'h300) begin
            n_fail++; $display("FAIL stallflush_target: got v=%b pc=%h expected v=1 pc=00000300",
                               instr_valid_decode, pc_decode);
        end
        n_checks++;
        if (acc_log.size() == 0 || acc_log[0] !== 32'h300) begin
            n_fail++; $display("FAIL stallflush_req_addr: got %h expected 00000300",
                               (acc_log.size() > 0) ? acc_log[0] : 32'hxxxxxxxx);
        end
    endtask

    task automatic test_jalr();
        int guard;
        flush_if    = 1'b1;
        pc_sel      = SEL_JALR;
        jalr_target = 32'h0000_0203;
        tick();
        flush_if = 1'b0;
        pc_sel   = SEL_FOUR;
        n_checks++;
        if (imem_req_addr !== 32'h200) begin
            n_fail++; $display("FAIL jalr_req_addr: got %h expected 00000200", imem_req_addr);
        end
        guard = 0;
        while (!instr_valid_decode && guard < 10) begin
            tick();
            guard++;
        end
        n_checks++;
        if (instr_valid_decode !== 1'b1 || pc_decode !== 32'h200 || instr_decode !== mem_word(32'h200)) begin
            n_fail++; $display("FAIL jalr_target: got v=%b pc=%h instr=%h expected v=1 pc=00000200 instr=%h",
                               instr_valid_decode, pc_decode, instr_decode, mem_word(32'h200));
        end
        exp_pc = 32'h204;
    endtask

    task automatic test_random_reset();
        int nvalid;
        rand_ready = 1'b1;
        lat_min    = 1;
        lat_max    = 3;
        nvalid     = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            n_checks++;
            if (mq.size() > 2) begin
                n_fail++; $display("FAIL rand_outstanding[%0d]: got %0d expected <=2", i, mq.size());
            end
            n_checks++;
            if (instr_valid_decode) begin
                if (pc_decode !== exp_pc || instr_decode !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL rand_seq[%0d]: got pc=%h instr=%h expected pc=%h",
                                       i, pc_decode, instr_decode, exp_pc);
                end
                exp_pc += 32'd4;
                nvalid++;
            end else if (instr_decode !== NOP) begin
                n_fail++; $display("FAIL rand_bubble[%0d]: got %h expected %h", i, instr_decode, NOP);
            end
        end
        n_checks++;
        if (nvalid < 60) begin
            n_fail++; $display("FAIL rand_progress: got %0d expected >=60", nvalid);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (instr_valid_decode !== 1'b0 || instr_decode !== NOP || pc_decode !== 32'h0) begin
            n_fail++; $display("FAIL midrst_out: got v=%b instr=%h pc=%h expected v=0 instr=%h pc=00000000",
                               instr_valid_decode, instr_decode, pc_decode, NOP);
        end
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_req_valid: got %b expected 0", imem_req_valid);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL midrst_req: got v=%b addr=%h expected v=1 addr=00000000",
                               imem_req_valid, imem_req_addr);
        end
        exp_pc = 32'h0;
        nvalid = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (instr_valid_decode) begin
                n_checks++;
                if (pc_decode !== exp_pc || instr_decode !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL midrst_seq[%0d]: got pc=%h instr=%h expected pc=%h",
                                       i, pc_decode, instr_decode, exp_pc);
                end
                exp_pc += 32'd4;
                nvalid++;
            end
        end
        n_checks++;
        if (nvalid < 8) begin
            n_fail++; $display("FAIL midrst_progress: got %0d expected >=8", nvalid);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        cyc            = 0;
        last_due       = 0;
        lat_min        = 1;
        lat_max        = 1;
        rand_ready     = 1'b0;
        rst            = 1'b1;
        pc_sel         = SEL_FOUR;
        br_target      = '0;
        jal_target     = '0;
        jalr_target    = '0;
        stall_if       = 1'b0;
        flush_if       = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        exp_pc         = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_stall_flush();
        test_jalr();
        test_random_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
